// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: rebuilds LSB-first serial frames into WIDTH-bit words.
// Optional even-parity trailer bit enabled by defining SIPO_PARITY_EN.
module sipo_deserializer #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       serial_in,
    input  logic                       shift_en,
    input  logic                       clr,
    output logic [WIDTH-1:0]           parallel_out,
    output logic                       out_valid,
    output logic                       busy,
`ifdef SIPO_PARITY_EN
    output logic                       parity_err,
`endif
    output logic [$clog2(WIDTH+1)-1:0] bit_count
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             valid_q, valid_d;
`ifdef SIPO_PARITY_EN
    logic             perr_q, perr_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            sh_q    <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sh_q    <= sh_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
`ifdef SIPO_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // clr outranks shift_en; strobes default low so they last exactly one cycle
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sh_d    = sh_q;
        pout_d  = pout_q;
        valid_d = 1'b0;
`ifdef SIPO_PARITY_EN
        perr_d  = 1'b0;
`endif
        if (clr) begin
            state_d = IDLE;
            count_d = '0;
            sh_d    = '0;
        end else if (shift_en) begin
            case (state_q)
                IDLE, RECV: begin
                    sh_d = {serial_in, sh_q[WIDTH-1:1]};
                    if (count_q == LAST) begin
`ifdef SIPO_PARITY_EN
                        state_d = PAR;
                        count_d = CW'(WIDTH);
`else
                        state_d = IDLE;
                        count_d = '0;
                        pout_d  = sh_d;
                        valid_d = 1'b1;
`endif
                    end else begin
                        state_d = RECV;
                        count_d = count_q + 1'b1;
                    end
                end
`ifdef SIPO_PARITY_EN
                // data bits are already aligned; this edge only consumes parity
                PAR: begin
                    state_d = IDLE;
                    count_d = '0;
                    pout_d  = sh_q;
                    valid_d = 1'b1;
                    perr_d  = (^sh_q) ^ serial_in;
                end
`endif
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign parallel_out = pout_q;
    assign out_valid    = valid_q;
    assign busy         = (state_q != IDLE);
    assign bit_count    = count_q;
`ifdef SIPO_PARITY_EN
    assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed frames plus random traffic
// compared against a bit-queue reference model.
module tb_sipo_deserializer;

    localparam int W  = 16;
    localparam int CW = $clog2(W+1);
`ifdef SIPO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          serial_in = 1'b0;
    logic          shift_en = 1'b0;
    logic          clr = 1'b0;
    logic [W-1:0]  parallel_out;
    logic          out_valid;
    logic          busy;
    logic [CW-1:0] bit_count;
`ifdef SIPO_PARITY_EN
    logic          parity_err;
`endif

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .shift_en     (shift_en),
        .clr          (clr),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .busy         (busy),
`ifdef SIPO_PARITY_EN
        .parity_err   (parity_err),
`endif
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    int errCount   = 0;
    int checkCount = 0;
    int cycleNum   = 0;
    int validCount = 0;
    int lastValidCycle = 0;

    // Reference model: the bits of the current frame in arrival order
    logic         bitQ[$];
    logic [W-1:0] expOut   = '0;
    logic         expValid = 1'b0;
    logic         expPerr  = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycleNum);
        end
    endtask

    task automatic modelReset();
        bitQ.delete();
        expOut   = '0;
        expValid = 1'b0;
        expPerr  = 1'b0;
    endtask

    task automatic modelStep(input logic se, input logic si, input logic cl);
        logic [W-1:0] w;
        expValid = 1'b0;
        expPerr  = 1'b0;
        if (cl) begin
            bitQ.delete();
        end else if (se) begin
            bitQ.push_back(si);
            if (bitQ.size() == FRAME) begin
                w = '0;
                for (int i = 0; i < W; i++) w[i] = bitQ[i];
                expOut   = w;
                expValid = 1'b1;
`ifdef SIPO_PARITY_EN
                expPerr  = (^w) ^ bitQ[W];
`endif
                bitQ.delete();
            end
        end
    endtask

    task automatic checkAll();
        int cnt;
        cnt = (bitQ.size() > W) ? W : bitQ.size();
        checkOutput("out_valid", 64'(out_valid), 64'(expValid));
        checkOutput("parallel_out", 64'(parallel_out), 64'(expOut));
        checkOutput("busy", 64'(busy), 64'(bitQ.size() != 0));
        checkOutput("bit_count", 64'(bit_count), 64'(cnt));
`ifdef SIPO_PARITY_EN
        checkOutput("parity_err", 64'(parity_err), 64'(expPerr));
`endif
    endtask

    task automatic applyStimulus(input logic se, input logic si, input logic cl);
        @(negedge clk);
        shift_en  = se;
        serial_in = si;
        clr       = cl;
        @(posedge clk);
        #1;
        cycleNum++;
        modelStep(se, si, cl);
        if (out_valid) begin
            validCount++;
            lastValidCycle = cycleNum;
        end
        checkAll();
    endtask

    // Sends bits [0..nBits-1] of word, idling gapLen cycles after every gapEvery bits
    task automatic sendBits(input logic [63:0] word, input int nBits, input int gapEvery, input int gapLen);
        for (int i = 0; i < nBits; i++) begin
            applyStimulus(1'b1, word[i], 1'b0);
            if (gapEvery > 0 && ((i + 1) % gapEvery) == 0 && i != nBits - 1)
                for (int g = 0; g < gapLen; g++) applyStimulus(1'b0, $urandom_range(0, 1), 1'b0);
        end
    endtask

    task automatic sendFrame(input logic [W-1:0] word, input int gapEvery, input int gapLen);
        logic [63:0] f;
        f = 64'(word);
`ifdef SIPO_PARITY_EN
        f[W] = ^word;
`endif
        sendBits(f, FRAME, gapEvery, gapLen);
    endtask

    int c1, v0;
    logic [63:0] tmp;

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkAll();

        // Asynchronous reset mid-frame
        sendBits(64'h1F, 5, 0, 0);
        @(negedge clk);
        shift_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Basic frame then gapped frame
        sendFrame(16'hA5C3, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("basic_word", 64'(parallel_out), 64'h A5C3);
        sendFrame(16'h00FF, 4, 3);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Back-to-back frames
        sendFrame(16'h1234, 0, 0);
        tmp = 64'hFFFF;
`ifdef SIPO_PARITY_EN
        tmp[W] = 1'b0;
`endif
        applyStimulus(1'b1, tmp[0], 1'b0);
        c1 = lastValidCycle;
        checkOutput("b2b_first", 64'(parallel_out), 64'h1234);
        sendBits(tmp >> 1, FRAME - 1, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("b2b_gap", 64'(lastValidCycle - c1), 64'(FRAME));
        checkOutput("b2b_second", 64'(parallel_out), 64'hFFFF);

        // Abort after 9 bits, then a clean frame
        v0 = validCount;
        sendBits(64'hBEEF, 9, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        sendFrame(16'h0001, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort_valids", 64'(validCount - v0), 64'd1);

        // clr on the completing edge suppresses the completion
        v0 = validCount;
        sendBits(64'h5555, FRAME - 1, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("clr_last_valids", 64'(validCount - v0), 64'd0);

`ifdef SIPO_PARITY_EN
        sendBits(64'h0003, FRAME, 0, 0);
        sendBits(64'h0007, FRAME, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
`endif

        // Random traffic
        for (int n = 0; n < 600; n++)
            applyStimulus(($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 29) == 0));

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
